// File: rtl/mspu_dmem_pkg.sv
// Shared definitions for the data-memory load arbiter: FSM state encoding,
// default packet length and word-count width.
package mspu_dmem_pkg;

  // Arbiter phases: waiting for a packet, packet streaming in, packet owned by core
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } dmem_state_e;

  // Number of loader writes that make up one packet
  localparam int unsigned LOAD_WORDS_DEFAULT = 32'd512;

  // Width of the per-packet word counter
  localparam int unsigned WCNT_WIDTH = 32'd16;

endpackage

// File: rtl/dmem_load_arbiter_if.sv
// Bundle of loader, core, memory and status signals around the arbiter.
// slave  : the arbiter side
// master : the environment side (loader, core, memory, observer)
interface dmem_load_arbiter_if #(
  parameter int unsigned DROP_WIDTH = 32'd16
);

  // loader write stream (no backpressure)
  logic                  ld_we;
  logic [31:0]           ld_addr;
  logic [31:0]           ld_din;

  // core access port
  logic                  core_req;
  logic                  core_we;
  logic [31:0]           core_addr;
  logic [31:0]           core_din;
  logic                  core_gnt;
  logic                  core_rvalid;
  logic [31:0]           core_dout;
  logic                  core_release;

  // single-port data memory
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_din;
  logic [31:0]           mem_dout;

  // status
  logic                  pkt_ready;
  logic                  busy;
  logic [DROP_WIDTH-1:0] drop_count;

  modport slave (
    input  ld_we, ld_addr, ld_din,
    input  core_req, core_we, core_addr, core_din, core_release,
    output core_gnt, core_rvalid, core_dout,
    output mem_we, mem_addr, mem_din,
    input  mem_dout,
    output pkt_ready, busy, drop_count
  );

  modport master (
    output ld_we, ld_addr, ld_din,
    output core_req, core_we, core_addr, core_din, core_release,
    input  core_gnt, core_rvalid, core_dout,
    input  mem_we, mem_addr, mem_din,
    output mem_dout,
    input  pkt_ready, busy, drop_count
  );

endinterface

// File: rtl/dmem_load_arbiter.sv
// Arbitrates a single-port data memory between a packet loader and a core.
// IDLE  : loader has priority; first loader write starts a packet.
// LOAD  : only the loader reaches memory until LOAD_WORDS writes are seen.
// READY : core owns memory; loader writes are dropped and counted.
// Memory request outputs are registered; read data returns two cycles after
// grant through a 2-bit valid shift register.
module dmem_load_arbiter
  import mspu_dmem_pkg::*;
#(
  parameter int unsigned LOAD_WORDS = LOAD_WORDS_DEFAULT,
  parameter int unsigned DROP_WIDTH = 32'd16
) (
  input  logic                clk,
  input  logic                reset,
  dmem_load_arbiter_if.slave  bus
);

  localparam logic [WCNT_WIDTH-1:0] LW_CNT   = LOAD_WORDS[WCNT_WIDTH-1:0];
  localparam logic [WCNT_WIDTH-1:0] WCNT_MAX = {WCNT_WIDTH{1'b1}};
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = {DROP_WIDTH{1'b1}};
  localparam logic [DROP_WIDTH-1:0] DROP_ONE = DROP_WIDTH'(1);

  dmem_state_e            r_state;
  dmem_state_e            w_state_nxt;
  logic [WCNT_WIDTH-1:0]  r_wcnt;
  logic [WCNT_WIDTH-1:0]  w_wcnt_inc;
  logic [DROP_WIDTH-1:0]  r_drop_count;
  logic                   r_mem_we;
  logic [31:0]            r_mem_addr;
  logic [31:0]            r_mem_din;
  logic [1:0]             r_rvalid_sr;
  logic                   w_core_gnt;
  logic                   w_ld_accept;
  logic                   w_ld_drop;
  logic                   w_core_rd;

  // saturating increment keeps the word count from wrapping inside a packet
  assign w_wcnt_inc = (r_wcnt == WCNT_MAX) ? r_wcnt : (r_wcnt + 16'd1);
  assign w_core_rd  = w_core_gnt & ~bus.core_we;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: loader starts/completes a packet, core release ends it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.ld_we) begin
          w_state_nxt = (LW_CNT == 16'd1) ? ST_READY : ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (bus.ld_we && (w_wcnt_inc == LW_CNT)) begin
          w_state_nxt = ST_READY;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_READY: begin
        if (bus.core_release) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_READY;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Per-state arbitration decisions (grant, loader accept, loader drop)
  always_comb begin
    w_core_gnt  = 1'b0;
    w_ld_accept = 1'b0;
    w_ld_drop   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ld_accept = bus.ld_we;
        w_core_gnt  = bus.core_req & ~bus.ld_we;
      end
      ST_LOAD: begin
        w_ld_accept = bus.ld_we;
        w_core_gnt  = 1'b0;
      end
      ST_READY: begin
        w_ld_drop   = bus.ld_we;
        w_core_gnt  = bus.core_req;
      end
      default: begin
        w_core_gnt  = 1'b0;
        w_ld_accept = 1'b0;
        w_ld_drop   = 1'b0;
      end
    endcase
  end

  // Word counter: first packet write sets 1, later writes count up, release clears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wcnt <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.ld_we) begin
            r_wcnt <= 16'd1;
          end else begin
            r_wcnt <= r_wcnt;
          end
        end
        ST_LOAD: begin
          if (bus.ld_we) begin
            r_wcnt <= w_wcnt_inc;
          end else begin
            r_wcnt <= r_wcnt;
          end
        end
        ST_READY: begin
          if (bus.core_release) begin
            r_wcnt <= 16'd0;
          end else begin
            r_wcnt <= r_wcnt;
          end
        end
        default: begin
          r_wcnt <= 16'd0;
        end
      endcase
    end
  end

  // Saturating count of loader writes discarded while the core owns memory
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_count <= {DROP_WIDTH{1'b0}};
    end else if (w_ld_drop && (r_drop_count != DROP_MAX)) begin
      r_drop_count <= r_drop_count + DROP_ONE;
    end else begin
      r_drop_count <= r_drop_count;
    end
  end

  // Registered memory request; address/data hold when nothing is issued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_we   <= 1'b0;
      r_mem_addr <= 32'd0;
      r_mem_din  <= 32'd0;
    end else if (w_ld_accept) begin
      r_mem_we   <= 1'b1;
      r_mem_addr <= bus.ld_addr;
      r_mem_din  <= bus.ld_din;
    end else if (w_core_gnt) begin
      r_mem_we   <= bus.core_we;
      r_mem_addr <= bus.core_addr;
      r_mem_din  <= bus.core_din;
    end else begin
      r_mem_we   <= 1'b0;
      r_mem_addr <= r_mem_addr;
      r_mem_din  <= r_mem_din;
    end
  end

  // Read-valid pipeline: grant -> address registered -> memory data valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rvalid_sr <= 2'b00;
    end else begin
      r_rvalid_sr <= {r_rvalid_sr[0], w_core_rd};
    end
  end

  assign bus.core_gnt    = w_core_gnt;
  assign bus.core_rvalid = r_rvalid_sr[1];
  assign bus.core_dout   = r_rvalid_sr[1] ? bus.mem_dout : 32'd0;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_din     = r_mem_din;
  assign bus.pkt_ready   = (r_state == ST_READY);
  assign bus.busy        = (r_state == ST_LOAD);
  assign bus.drop_count  = r_drop_count;

endmodule

// File: tb/tb_dmem_load_arbiter.sv
// Directed + randomized bench for dmem_load_arbiter. Expected values come from
// a packet-level model: words loaded so far, drops seen, expected memory image.
module tb_dmem_load_arbiter;

  localparam int LW      = 512;
  localparam int DW      = 4;
  localparam int DROPSAT = (1 << DW) - 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_load_arbiter_if #(.DROP_WIDTH(DW)) bus ();

  dmem_load_arbiter #(.LOAD_WORDS(LW), .DROP_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  int total = 0;
  int bad   = 0;
  int words_model;
  int drops_model;
  int wa [0:3];

  // single-port memory with one cycle of read latency
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ld_we = 1'b0; bus.ld_addr = 32'd0; bus.ld_din = 32'd0;
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = 32'd0;
    bus.core_din = 32'd0; bus.core_release = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int drop_exp();
    return (drops_model > DROPSAT) ? DROPSAT : drops_model;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_mem_we"},  32'(bus.mem_we), 32'd0);
    chk({tag, "_addr"},    bus.mem_addr, 32'd0);
    chk({tag, "_din"},     bus.mem_din, 32'd0);
    chk({tag, "_rvalid"},  32'(bus.core_rvalid), 32'd0);
    chk({tag, "_dout"},    bus.core_dout, 32'd0);
    chk({tag, "_ready"},   32'(bus.pkt_ready), 32'd0);
    chk({tag, "_busy"},    32'(bus.busy), 32'd0);
    chk({tag, "_drops"},   32'(bus.drop_count), 32'd0);
  endtask

  task automatic core_write(input string tag, input int a, input logic [31:0] d);
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 32'(a); bus.core_din = d;
    #1 chk({tag, "_gnt"}, 32'(bus.core_gnt), 32'd1);
    tick();
    idle_inputs();
    ref_mem[a] = d;
    chk({tag, "_we"},   32'(bus.mem_we), 32'd1);
    chk({tag, "_addr"}, bus.mem_addr, 32'(a));
    chk({tag, "_din"},  bus.mem_din, d);
  endtask

  task automatic core_read(input string tag, input int a);
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'(a);
    #1 chk({tag, "_gnt"}, 32'(bus.core_gnt), 32'd1);
    tick();
    idle_inputs();
    chk({tag, "_we0"},  32'(bus.mem_we), 32'd0);
    chk({tag, "_addr"}, bus.mem_addr, 32'(a));
    chk({tag, "_rv1"},  32'(bus.core_rvalid), 32'd0);
    tick();
    chk({tag, "_rv2"},  32'(bus.core_rvalid), 32'd1);
    chk({tag, "_data"}, bus.core_dout, ref_mem[a]);
    tick();
    chk({tag, "_rv3"},  32'(bus.core_rvalid), 32'd0);
  endtask

  // one loader packet (or part of one); optional random gaps with core pokes
  task automatic load_words(input string tag, input int n, input bit gaps);
    logic [31:0] d;
    int g;
    for (int i = 0; i < n; i++) begin
      g = gaps ? $urandom_range(0, 2) : 0;
      for (int k = 0; k < g; k++) begin
        bus.ld_we = 1'b0;
        if (words_model > 0) begin
          bus.core_req = 1'($urandom_range(0, 1));
          bus.core_release = (i == 50) ? 1'b1 : 1'b0;
          #1 chk({tag, "_gap_gnt"}, 32'(bus.core_gnt), 32'd0);
        end
        tick();
        idle_inputs();
        chk({tag, "_gap_busy"},  32'(bus.busy), 32'(words_model > 0));
        chk({tag, "_gap_ready"}, 32'(bus.pkt_ready), 32'd0);
      end
      d = $urandom;
      bus.ld_we = 1'b1; bus.ld_addr = 32'(i); bus.ld_din = d;
      if (i == 0 || i == 7) begin
        bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 32'd1000; bus.core_din = 32'hDEAD;
        #1 chk({tag, "_ld_prio_gnt"}, 32'(bus.core_gnt), 32'd0);
      end
      tick();
      idle_inputs();
      ref_mem[i] = d;
      words_model++;
      chk({tag, "_we"},    32'(bus.mem_we), 32'd1);
      chk({tag, "_addr"},  bus.mem_addr, 32'(i));
      chk({tag, "_din"},   bus.mem_din, d);
      chk({tag, "_busy"},  32'(bus.busy), 32'(words_model < LW));
      chk({tag, "_ready"}, 32'(bus.pkt_ready), 32'(words_model == LW));
    end
  endtask

  initial begin
    logic [31:0] d;
    int r;
    idle_inputs();
    reset = 1'b0;
    words_model = 0;
    drops_model = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    reset = 1'b1;

    // idle core write, then a few random writes and read-backs
    core_write("idle_wr", 32'h10, 32'hAA);
    for (int i = 0; i < 4; i++) begin
      wa[i] = $urandom_range(600, 999);
      if (i > 0 && wa[i] == wa[i-1]) wa[i] = wa[i] + 1;
      core_write("rnd_wr", wa[i], $urandom);
    end
    for (int i = 0; i < 4; i++) core_read("rnd_rd", wa[i]);
    core_read("rd_10", 32'h10);

    // packet 1: consecutive loader writes, first one collides with a core request
    load_words("pkt1", LW, 1'b0);
    core_read("rd_w5", 5);

    // drops while READY; third one coincides with a granted core write
    for (int i = 0; i < 3; i++) begin
      bus.ld_we = 1'b1; bus.ld_addr = 32'(wa[0]); bus.ld_din = $urandom;
      if (i == 2) begin
        d = $urandom;
        bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 32'(wa[1]); bus.core_din = d;
        #1 chk("rdy_wr_gnt", 32'(bus.core_gnt), 32'd1);
      end
      tick();
      idle_inputs();
      drops_model++;
      chk("drop_cnt", 32'(bus.drop_count), 32'(drop_exp()));
      if (i == 2) begin
        ref_mem[wa[1]] = d;
        chk("rdy_wr_we",   32'(bus.mem_we), 32'd1);
        chk("rdy_wr_addr", bus.mem_addr, 32'(wa[1]));
      end else begin
        chk("drop_no_we", 32'(bus.mem_we), 32'd0);
      end
    end
    core_read("drop_kept", wa[0]);
    core_read("rdy_wr_rd", wa[1]);

    // release + read + drop all in one cycle; the read still returns
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'd5; bus.core_release = 1'b1;
    bus.ld_we = 1'b1; bus.ld_addr = 32'(wa[2]); bus.ld_din = $urandom;
    #1 chk("rel_gnt", 32'(bus.core_gnt), 32'd1);
    tick();
    idle_inputs();
    drops_model++;
    words_model = 0;
    chk("rel_ready", 32'(bus.pkt_ready), 32'd0);
    chk("rel_busy",  32'(bus.busy), 32'd0);
    chk("rel_drop",  32'(bus.drop_count), 32'(drop_exp()));
    chk("rel_we",    32'(bus.mem_we), 32'd0);
    tick();
    chk("rel_rv",    32'(bus.core_rvalid), 32'd1);
    chk("rel_data",  bus.core_dout, ref_mem[5]);
    tick();
    chk("rel_rv_end", 32'(bus.core_rvalid), 32'd0);

    // release while IDLE has no effect
    bus.core_release = 1'b1;
    tick();
    idle_inputs();
    chk("idle_rel_ready", 32'(bus.pkt_ready), 32'd0);
    chk("idle_rel_busy",  32'(bus.busy), 32'd0);
    core_read("idle_rd2", wa[2]);

    // packet 2 interrupted by reset after 100 words
    load_words("pkt2", 100, 1'b1);
    #2 reset = 1'b0;
    #1 check_zero("rst_mid");
    words_model = 0;
    drops_model = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // packet 3 needs the full count again
    load_words("pkt3", LW, 1'b1);
    r = $urandom_range(0, LW - 1);
    core_read("pkt3_rd", r);

    // drop counter saturation
    for (int i = 0; i < DROPSAT + 6; i++) begin
      bus.ld_we = 1'b1; bus.ld_addr = 32'd0; bus.ld_din = $urandom;
      tick();
      idle_inputs();
      drops_model++;
      chk("sat_drop", 32'(bus.drop_count), 32'(drop_exp()));
    end
    core_read("sat_rd0", 0);

    // read in flight is discarded by reset
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'd3;
    #1 chk("fly_gnt", 32'(bus.core_gnt), 32'd1);
    tick();
    idle_inputs();
    #2 reset = 1'b0;
    #1 check_zero("rst_fly");
    tick();
    chk("fly_rv", 32'(bus.core_rvalid), 32'd0);
    reset = 1'b1;
    tick();
    chk("fly_rv_after", 32'(bus.core_rvalid), 32'd0);
    chk("fly_ready",    32'(bus.pkt_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
